uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//  - 8-bit UART transmitter: 1 start bit, 8 data bits LSB first, 1 stop bit; optional parity.
//  - Transmit side of the UART peripheral on the APB bus, paired with the existing receiver.
//  - Fed by the APB interface through tx_start/tx_data; reports status back through busy/done.
// PARAMETERS
//  - CLOCK_RATE  100000000  input clock frequency in Hz
//  - BAUD_RATE   9600       serial bit rate in baud
//  - CLKS_PER_BIT (localparam) = CLOCK_RATE/BAUD_RATE, integer floor (10416 at defaults).
//    Elaboration error if < 2.
// PORTS
//  - clk       in   1  single clock; all state changes on the rising edge
//  - rst       in   1  asynchronous reset, active-high
//  - tx_en     in   1  transmitter enable (driven from pen); gates acceptance of new frames only
//  - tx_start  in   1  frame request; sampled only in IDLE while tx_en=1
//  - tx_data   in   8  payload; captured on the accept edge
//  - txd       out  1  serial line; idle level is 1
//  - busy      out  1  1 from the cycle after accept until the stop bit completes
//  - done      out  1  one-cycle pulse when the stop bit completes
// BEHAVIOUR
//  - Reset (async, any state): txd=1, busy=0, done=0, FSM=IDLE, bit/baud counters=0, shift reg=0.
//  - FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//  - IDLE: txd=1, busy=0. If tx_en & tx_start at edge N: latch tx_data, go to START.
//    From cycle N+1: txd=0, busy=1.
//  - Baud counter: counts 0..CLKS_PER_BIT-1, then wraps to 0. Each bit is held exactly
//    CLKS_PER_BIT cycles. The counter is cleared on accept.
//  - DATA: bit counter runs 0..7. txd = shift_reg[0]. Shift right at each bit end.
//    After bit 7, go to STOP (or PARITY).
//  - STOP: txd=1 for CLKS_PER_BIT cycles. At its end: FSM=IDLE, busy=0, done=1 for one cycle.
//  - Frame length: 10*CLKS_PER_BIT cycles without parity, 11*CLKS_PER_BIT with parity.
//  - Back-to-back: tx_start in the cycle done=1 is accepted, so there is no idle gap between frames.
//  - tx_start while busy: ignored. No queueing, and no effect on the current frame.
//  - tx_data changes mid-frame: no effect; only the latched copy is shifted.
//  - tx_en dropped mid-frame: current frame completes normally; no new accept until tx_en=1.
//  - tx_start and tx_en both held high: a new frame starts every frame period.
//  - Reset mid-frame: line returns to 1 immediately. Partial frame is abandoned; no done pulse.
// CONFIGURATION
//  - Macro UART_TX_PARITY_EN.
//  - Defined: a PARITY state sits between DATA and STOP and sends one bit time of
//    even parity (XOR of the 8 latched bits). Frame = 11 bits.
//  - Undefined: no PARITY state and no parity logic. Frame = 10 bits.
//    The port list is the same in both builds.
// STRUCTURE
//  - Shared package uart_pkg:
//    - typedef uart_state_e {IDLE, START, DATA, PARITY, STOP}
//    - UART_DATA_BITS=8 and UART_STOP_BITS=1
//    - function clks_per_bit(clock_rate, baud_rate); the receiver uses the same function.
//  - One sub-module, uart_baud_tick: baud counter with a clear input.
//    Emits bit_end when count==CLKS_PER_BIT-1. Same async active-high reset.
//  - FSM, shift register and bit counter live in uart_tx itself.
// TESTING (CLOCK_RATE=16, BAUD_RATE=1 -> CLKS_PER_BIT=16)
//  - Reset: assert rst mid-run -> txd=1, busy=0, done=0 with no clock edge needed.
//  - Single frame: tx_data=8'hA5 with a 1-cycle tx_start ->
//    - line = 0,1,0,1,0,0,1,0,1,1 (start, data LSB first, stop), each bit 16 cycles;
//    - done pulses once at cycle 160 after accept; busy is high for cycles 1..160.
//  - Back-to-back: tx_start held high with 8'h00 then 8'hFF ->
//    - two frames with no idle cycle between them;
//    - second start bit begins the cycle after the first done.
//  - Ignored request: pulse tx_start with 8'h3C at bit 4 of an 8'h81 frame ->
//    - 8'h81 frame is unchanged; exactly one done pulse.
//  - tx_en=0 with tx_start=1 -> txd stays 1, busy stays 0 for 200 cycles.
//    Then drop tx_en mid-frame -> that frame still completes.
//  - Parity (UART_TX_PARITY_EN defined): 8'h07 -> parity bit 1, 176-cycle frame.
//    8'h03 -> parity bit 0.
//  - Reset mid-frame at bit 3 of 8'h55 -> txd=1 at once, no done pulse;
//    a new 8'h55 frame after reset is bit-exact.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and baud divisor helper.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned UART_STOP_BITS = 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  // Integer-floor divisor shared with the receiver so both sides agree on bit timing.
  function automatic int unsigned clks_per_bit(input int unsigned clock_rate,
                                               input int unsigned baud_rate);
    return clock_rate / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || bit_end) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign bit_end = (count == CW'(CLKS_PER_BIT - 1));

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter; defining UART_TX_PARITY_EN inserts an even-parity bit before stop.
// Port list is identical in both builds.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_RATE = 100000000,
  parameter int unsigned BAUD_RATE  = 9600
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tx_en,
  input  logic                      tx_start,
  input  logic [UART_DATA_BITS-1:0] tx_data,
  output logic                      txd,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLOCK_RATE, BAUD_RATE);
  localparam int unsigned BCW          = $clog2(UART_DATA_BITS);

  if (CLKS_PER_BIT < 2) begin : g_cpb_check
    $error("uart_tx: CLOCK_RATE/BAUD_RATE must be at least 2");
  end

  uart_state_e               state;
  logic [UART_DATA_BITS-1:0] shift_reg;
  logic [BCW-1:0]            bit_cnt;
  logic                      accept;
  logic                      bit_end;

  assign accept = (state == IDLE) && tx_en && tx_start;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .bit_end(bit_end)
  );

`ifdef UART_TX_PARITY_EN
  logic parity_bit;

  // Parity is taken from the latched payload because the shifter destroys it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_bit <= 1'b0;
    end else if (accept) begin
      parity_bit <= ^tx_data;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      txd       <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            shift_reg <= tx_data;
            bit_cnt   <= '0;
            txd       <= 1'b0;
            busy      <= 1'b1;
            state     <= START;
          end else begin
            txd  <= 1'b1;
            busy <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            txd   <= shift_reg[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            shift_reg <= {1'b0, shift_reg[UART_DATA_BITS-1:1]};
            if (bit_cnt == BCW'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              txd   <= parity_bit;
              state <= PARITY;
`else
              txd   <= 1'b1;
              state <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + BCW'(1);
              txd     <= shift_reg[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            txd   <= 1'b1;
            state <= STOP;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          txd   <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=16; follows UART_TX_PARITY_EN for frame shape.
module tb_uart_tx;

  localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  logic       clk;
  logic       rst;
  logic       tx_en;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       txd;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  uart_tx #(
    .CLOCK_RATE(16),
    .BAUD_RATE (1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_en   (tx_en),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .txd     (txd),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line level for frame bit position idx (0 = start bit).
  function automatic logic frame_bit(input logic [7:0] d, input int idx);
    logic [7:0] v;
    v = d;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return v[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^v;
`endif
    return 1'b1;
  endfunction

  // Entered at the first falling edge after the accept edge; leaves one cycle after done.
  task automatic expect_frame(input string name, input logic [7:0] d, input int poke_k,
                              input logic poke_start, input logic [7:0] poke_data,
                              input logic poke_en, input bit release_start);
    for (int k = 1; k <= FRAME_CYC + 1; k++) begin
      if (k == poke_k) begin
        tx_start = poke_start;
        tx_data  = poke_data;
        tx_en    = poke_en;
      end
      if (release_start && k == poke_k + 1) tx_start = 1'b0;
      if (k <= FRAME_CYC) begin
        check($sformatf("%s txd k=%0d", name, k), 32'(txd), 32'(frame_bit(d, (k - 1) / CPB)));
        check($sformatf("%s busy k=%0d", name, k), 32'(busy), 32'(1));
        check($sformatf("%s done k=%0d", name, k), 32'(done), 32'(0));
      end else begin
        check($sformatf("%s end txd", name), 32'(txd), 32'(1));
        check($sformatf("%s end busy", name), 32'(busy), 32'(0));
        check($sformatf("%s end done", name), 32'(done), 32'(1));
      end
      @(negedge clk);
    end
  endtask

  task automatic start_frame(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // Counts cycles over a window where the line is not idle or a done pulse appears.
  task automatic quiet_window(input string name, input int cycles);
    int bad;
    int pulses;
    bad    = 0;
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      if (txd !== 1'b1 || busy !== 1'b0) bad++;
      if (done === 1'b1) pulses++;
      @(negedge clk);
    end
    check($sformatf("%s idle", name), 32'(bad), 32'(0));
    check($sformatf("%s done", name), 32'(pulses), 32'(0));
  endtask

  initial begin
    rst      = 1'b1;
    tx_en    = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("reset txd", 32'(txd), 32'(1));
    check("reset busy", 32'(busy), 32'(0));
    check("reset done", 32'(done), 32'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    start_frame(8'hA5);
    expect_frame("a5", 8'hA5, 0, 1'b0, 8'h00, 1'b1, 1'b0);
    quiet_window("a5 after", 20);

    tx_data  = 8'h00;
    tx_start = 1'b1;
    @(negedge clk);
    expect_frame("b2b_00", 8'h00, 1, 1'b1, 8'hFF, 1'b1, 1'b0);
    expect_frame("b2b_ff", 8'hFF, 1, 1'b0, 8'hFF, 1'b1, 1'b0);
    quiet_window("b2b after", 20);

    start_frame(8'h81);
    expect_frame("ign_81", 8'h81, 4 * CPB + 8 + 16, 1'b1, 8'h3C, 1'b1, 1'b1);
    quiet_window("ign after", 40);

    tx_en    = 1'b0;
    tx_start = 1'b1;
    tx_data  = 8'h5A;
    quiet_window("en_low", 200);
    tx_en = 1'b1;
    @(negedge clk);
    expect_frame("en_drop", 8'h5A, 50, 1'b1, 8'h5A, 1'b0, 1'b0);
    quiet_window("en_drop after", 40);
    tx_start = 1'b0;
    tx_en    = 1'b1;
    @(negedge clk);

    start_frame(8'h07);
    expect_frame("p07", 8'h07, 0, 1'b0, 8'h00, 1'b1, 1'b0);
    start_frame(8'h03);
    expect_frame("p03", 8'h03, 0, 1'b0, 8'h00, 1'b1, 1'b0);
    quiet_window("p03 after", 10);

    start_frame(8'h55);
    for (int k = 1; k < 70; k++) begin
      check($sformatf("rst55 txd k=%0d", k), 32'(txd), 32'(frame_bit(8'h55, (k - 1) / CPB)));
      @(negedge clk);
    end
    check("rst55 pre txd", 32'(txd), 32'(0));
    #2 rst = 1'b1;
    #1;
    check("rst55 async txd", 32'(txd), 32'(1));
    check("rst55 async busy", 32'(busy), 32'(0));
    check("rst55 async done", 32'(done), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    quiet_window("rst55 after", 40);
    start_frame(8'h55);
    expect_frame("post_rst55", 8'h55, 0, 1'b0, 8'h00, 1'b1, 1'b0);
    quiet_window("post_rst55 after", 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
